// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_IF = 2'd1,
    S_WAIT_LS = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

  localparam logic [3:0] LEN_B = 4'd1;
  localparam logic [3:0] LEN_H = 4'd2;
  localparam logic [3:0] LEN_W = 4'd4;
  localparam logic [3:0] LEN_D = 4'd8;

  localparam int TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: gnt[0] = fetch, gnt[1] = load/store.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  owner_t     last,
  output logic [1:0] gnt
);

  // A tie goes to whichever side did not win last; a lone request passes through.
  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = (last == OWN_LS) ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch / load-store arbiter in front of a single-port memory, one read outstanding.
//
// state     | meaning
// S_IDLE    | arbitrate, drive the winner's command onto mem_*
// S_WAIT_IF | fetch read accepted, waiting for mem_rvalid or timeout
// S_WAIT_LS | load read accepted, waiting for mem_rvalid or timeout
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  input  logic [3:0]        ls_len,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_len,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err
);

  state_t     state, state_nxt;
  owner_t     last_owner, pend_owner, owner;
  logic       pend_vld;
  logic [3:0] wait_cnt;
  logic [1:0] pick_gnt;
  logic       timeout_hit;

  rr_pick2 u_pick (
    .req  ({ls_req, if_req}),
    .last (last_owner),
    .gnt  (pick_gnt)
  );

  // Next state and all command/response outputs; a stalled winner keeps ownership.
  always_comb begin
    owner       = pick_gnt[1] ? OWN_LS : OWN_IF;
    if (pend_vld) owner = pend_owner;
    timeout_hit = (state != S_IDLE) && !mem_rvalid && (wait_cnt == 4'(TIMEOUT));
    state_nxt   = state;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_len     = '0;
    if_gnt      = 1'b0;
    ls_gnt      = 1'b0;
    if_rvalid   = 1'b0;
    if_rdata    = '0;
    ls_rvalid   = 1'b0;
    ls_rdata    = '0;
    case (state)
      S_IDLE: begin
        // rst gating keeps the combinational command quiet while reset is held
        mem_req = rst && (pend_vld || (|pick_gnt));
        if (mem_req) begin
          if (owner == OWN_LS) begin
            mem_we    = ls_we;
            mem_addr  = ls_addr;
            mem_wdata = ls_wdata;
            mem_len   = ls_len;
          end else begin
            mem_addr  = if_addr;
            mem_len   = LEN_W;
          end
          if (mem_ready) begin
            if_gnt = (owner == OWN_IF);
            ls_gnt = (owner == OWN_LS);
            if (!mem_we) state_nxt = (owner == OWN_LS) ? S_WAIT_LS : S_WAIT_IF;
          end
        end
      end
      S_WAIT_IF: begin
        if (mem_rvalid || timeout_hit) begin
          if_rvalid = 1'b1;
          if_rdata  = mem_rvalid ? mem_rdata[31:0] : '0;
          state_nxt = S_IDLE;
        end
      end
      S_WAIT_LS: begin
        if (mem_rvalid || timeout_hit) begin
          ls_rvalid = 1'b1;
          ls_rdata  = mem_rvalid ? mem_rdata : '0;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Ownership history, pending-winner latch, saturating wait counter and sticky error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_owner <= OWN_LS;
      pend_owner <= OWN_IF;
      pend_vld   <= 1'b0;
      wait_cnt   <= '0;
      err        <= 1'b0;
    end else begin
      if (state == S_IDLE && mem_req) begin
        if (mem_ready) begin
          last_owner <= owner;
          pend_vld   <= 1'b0;
        end else begin
          pend_owner <= owner;
          pend_vld   <= 1'b1;
        end
      end
      if (state == S_IDLE)                        wait_cnt <= '0;
      else if (!mem_rvalid && wait_cnt != 4'hF)   wait_cnt <= wait_cnt + 4'd1;
      if ((state == S_IDLE && mem_rvalid) || timeout_hit) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenarios plus a randomized run against a transaction-level model.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 11;
  localparam int DW = 64;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_gnt, if_rvalid;
  logic [31:0]   if_rdata;
  logic          ls_req = 1'b0, ls_we = 1'b0;
  logic [AW-1:0] ls_addr = '0;
  logic [DW-1:0] ls_wdata = '0;
  logic [3:0]    ls_len = '0;
  logic          ls_gnt, ls_rvalid;
  logic [DW-1:0] ls_rdata;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_len;
  logic          mem_ready = 1'b0, mem_rvalid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          err;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_len(ls_len),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_len(mem_len),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic idle_in();
    if_req = 0; ls_req = 0; ls_we = 0; mem_rvalid = 0; mem_ready = 1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 0; if_req = 1; mem_ready = 1; mem_rvalid = 0; #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_if_gnt", if_gnt, 0);
    chk("rst_rvalid", {if_rvalid, ls_rvalid}, 0);
    chk("rst_err", err, 0);
    @(negedge clk);
    idle_in(); rst = 1;
  endtask

  // random-run model state
  bit          m_last, m_pend, m_pend_own, m_busy, m_busy_own, win, any;
  int          m_cnt;
  logic [AW-1:0] m_raddr;
  bit          if_act, ls_act, ls_w;
  logic [AW-1:0] if_a, ls_a;
  logic [DW-1:0] ls_d;
  logic [3:0]  ls_l;
  bit          e_ifg, e_lsg, e_req, e_ifv, e_lsv;
  logic [DW-1:0] e_data;
  int          to_k;
  logic [DW-1:0] d1;

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = {$urandom, $urandom};

    // single fetch, latency 2
    do_reset();
    @(negedge clk); if_req = 1; if_addr = 11'h010; #1;
    chk("f_gnt", if_gnt, 1); chk("f_addr", mem_addr, 11'h010); chk("f_we", mem_we, 0); chk("f_ls_gnt", ls_gnt, 0);
    @(negedge clk); if_req = 0; #1;
    chk("f_wait_rv", if_rvalid, 0); chk("f_wait_req", mem_req, 0);
    @(negedge clk); mem_rvalid = 1; mem_rdata = 64'hCAFEF00D_00100093; #1;
    chk("f_rvalid", if_rvalid, 1); chk("f_rdata", if_rdata, 32'h00100093);
    chk("f_ls_rv", ls_rvalid, 0); chk("f_ls_rdata", ls_rdata, 0);
    @(negedge clk); mem_rvalid = 0; #1;
    chk("f_rv_pulse", if_rvalid, 0); chk("f_err", err, 0);

    // tie after reset: fetch first, load after fetch completes
    do_reset();
    @(negedge clk); if_req = 1; if_addr = 11'h020; ls_req = 1; ls_we = 0; ls_addr = 11'h100; ls_len = LEN_D; #1;
    chk("t_if_gnt", if_gnt, 1); chk("t_ls_gnt0", ls_gnt, 0); chk("t_addr0", mem_addr, 11'h020);
    @(negedge clk); if_req = 0; #1;
    chk("t_ls_gnt1", ls_gnt, 0); chk("t_req1", mem_req, 0);
    @(negedge clk); mem_rvalid = 1; mem_rdata = 64'h1111_2222_3333_4444; #1;
    chk("t_if_rv", if_rvalid, 1); chk("t_ls_gnt2", ls_gnt, 0);
    @(negedge clk); mem_rvalid = 0; #1;
    chk("t_ls_gnt3", ls_gnt, 1); chk("t_addr3", mem_addr, 11'h100); chk("t_len3", mem_len, LEN_D);
    @(negedge clk); ls_req = 0; #1;
    chk("t_ls_rv4", ls_rvalid, 0);
    @(negedge clk); mem_rvalid = 1; d1 = {$urandom, $urandom}; mem_rdata = d1; #1;
    chk("t_ls_rv5", ls_rvalid, 1); chk("t_ls_rdata", ls_rdata, d1); chk("t_if_rv5", if_rvalid, 0);

    // store stream, then an immediate fetch proves the FSM stayed idle
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); mem_rvalid = 0; ls_req = 1; ls_we = 1; ls_addr = 11'(11'h200 + 8 * i);
      ls_wdata = {$urandom, $urandom}; ls_len = LEN_D; #1;
      chk("s_gnt", ls_gnt, 1); chk("s_we", mem_we, 1); chk("s_addr", mem_addr, ls_addr);
      chk("s_wdata", mem_wdata, ls_wdata); chk("s_rv", {if_rvalid, ls_rvalid}, 0);
    end
    @(negedge clk); ls_req = 0; ls_we = 0; if_req = 1; if_addr = 11'h050; #1;
    chk("s_idle_fetch", if_gnt, 1);
    @(negedge clk); if_req = 0; mem_rvalid = 1; mem_rdata = 64'h0000_0000_0000_ABCD; #1;
    chk("s_fetch_rv", if_rvalid, 1); chk("s_fetch_rd", if_rdata, 32'h0000ABCD);

    // backpressure: last owner is fetch, yet a stalled fetch keeps the bus
    @(negedge clk); mem_rvalid = 0; mem_ready = 0; if_req = 1; if_addr = 11'h040; #1;
    chk("b_req", mem_req, 1); chk("b_addr0", mem_addr, 11'h040); chk("b_gnt0", if_gnt, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); ls_req = 1; ls_we = 0; ls_addr = 11'h180; ls_len = LEN_W; #1;
      chk("b_addr_hold", mem_addr, 11'h040); chk("b_no_ls", ls_gnt, 0);
    end
    @(negedge clk); mem_ready = 1; #1;
    chk("b_if_gnt", if_gnt, 1); chk("b_ls_gnt", ls_gnt, 0);
    @(negedge clk); if_req = 0; #1;
    chk("b_ls_wait", ls_gnt, 0);
    @(negedge clk); mem_rvalid = 1; mem_rdata = 64'h5; #1;
    chk("b_if_rv", if_rvalid, 1);
    @(negedge clk); mem_rvalid = 0; #1;
    chk("b_ls_gnt_late", ls_gnt, 1); chk("b_ls_addr", mem_addr, 11'h180);
    @(negedge clk); ls_req = 0; mem_rvalid = 1; mem_rdata = 64'h77; #1;
    chk("b_ls_rv", ls_rvalid, 1); chk("b_ls_rd", ls_rdata, 64'h77);

    // timeout on a load
    @(negedge clk); mem_rvalid = 0; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF; ls_req = 1; ls_we = 0; ls_addr = 11'h300; #1;
    chk("o_gnt", ls_gnt, 1);
    to_k = -1;
    for (int k = 1; k <= TO + 4 && to_k < 0; k++) begin
      @(negedge clk); ls_req = 0; #1;
      if (ls_rvalid) begin
        to_k = k;
        chk("o_rdata", ls_rdata, 0);
      end
    end
    chk("o_cycle", to_k, TO + 1);
    @(negedge clk); #1; chk("o_err", err, 1);
    repeat (3) @(negedge clk);
    #1; chk("o_err_sticky", err, 1);

    // reset in the middle of a load, then a late response
    do_reset();
    chk("r_err_clr", err, 0);
    @(negedge clk); ls_req = 1; ls_we = 0; ls_addr = 11'h380; #1;
    chk("r_gnt", ls_gnt, 1);
    @(negedge clk); rst = 0; if_req = 1; #1;
    chk("r_in_rst", {mem_req, if_gnt, ls_gnt, ls_rvalid, if_rvalid, err}, 0);
    @(negedge clk); rst = 1; idle_in();
    @(negedge clk); mem_rvalid = 1; mem_rdata = 64'h1234; #1;
    chk("r_late_rv", ls_rvalid, 0); chk("r_late_rd", ls_rdata, 0);
    @(negedge clk); mem_rvalid = 0; #1;
    chk("r_late_err", err, 1);

    // randomized traffic against the transaction model
    do_reset();
    m_last = 1; m_pend = 0; m_busy = 0; m_cnt = 0; if_act = 0; ls_act = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (!if_act && $urandom_range(0, 2) == 0) begin
        if_act = 1; if_a = AW'($urandom);
      end
      if (!ls_act && $urandom_range(0, 2) == 0) begin
        ls_act = 1; ls_a = AW'($urandom); ls_w = 1'($urandom); ls_d = {$urandom, $urandom};
        case ($urandom_range(0, 3))
          0: ls_l = LEN_B;
          1: ls_l = LEN_H;
          2: ls_l = LEN_W;
          default: ls_l = LEN_D;
        endcase
      end
      if_req = if_act; if_addr = if_a;
      ls_req = ls_act; ls_we = ls_w; ls_addr = ls_a; ls_wdata = ls_d; ls_len = ls_l;
      mem_ready = ($urandom_range(0, 3) != 0);
      mem_rvalid = m_busy && (m_cnt == 1);
      mem_rdata = mem_rvalid ? mem[m_raddr] : {$urandom, $urandom};
      #1;
      e_ifg = 0; e_lsg = 0; e_req = 0; e_ifv = 0; e_lsv = 0; e_data = '0; any = 0; win = 0;
      if (m_busy) begin
        if (mem_rvalid) begin
          e_ifv = !m_busy_own; e_lsv = m_busy_own; e_data = mem[m_raddr];
        end
      end else begin
        any = m_pend || if_act || ls_act;
        if (m_pend)                 win = m_pend_own;
        else if (if_act && ls_act)  win = !m_last;
        else                        win = ls_act;
        e_req = any;
        if (any && mem_ready) begin
          e_ifg = !win; e_lsg = win;
        end
      end
      chk("x_if_gnt", if_gnt, e_ifg);
      chk("x_ls_gnt", ls_gnt, e_lsg);
      chk("x_mem_req", mem_req, e_req);
      if (e_req) begin
        chk("x_mem_addr", mem_addr, win ? ls_a : if_a);
        chk("x_mem_we", mem_we, win ? ls_w : 1'b0);
        if (win) chk("x_mem_len", mem_len, ls_l);
        if (win && ls_w) chk("x_mem_wdata", mem_wdata, ls_d);
      end
      chk("x_if_rv", if_rvalid, e_ifv);
      chk("x_ls_rv", ls_rvalid, e_lsv);
      if (e_ifv) chk("x_if_rdata", if_rdata, e_data[31:0]);
      if (e_lsv) chk("x_ls_rdata", ls_rdata, e_data);
      chk("x_err", err, 0);
      if (m_busy) begin
        if (mem_rvalid) m_busy = 0;
        else            m_cnt--;
      end else if (any) begin
        if (mem_ready) begin
          m_last = win; m_pend = 0;
          if (win && ls_w) begin
            mem[ls_a] = ls_d;
          end else begin
            m_busy = 1; m_busy_own = win; m_cnt = $urandom_range(1, 3);
            m_raddr = win ? ls_a : if_a;
          end
          if (win) ls_act = 0;
          else     if_act = 0;
        end else begin
          m_pend = 1; m_pend_own = win;
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-port unified memory between the instruction-fetch path (driven by the PC) and the load/store path (driven by the ALU address and rs2 data). It sits between the core and the memory, with one transaction outstanding at a time. Simultaneous requests are resolved by two-way round-robin. Read responses are returned to the requester that issued them, and the block flags protocol errors and response timeouts.

## Interface
- ADDR_W, 11, memory byte-address width
- DATA_W, 64, data-path width
- TIMEOUT, 15, maximum cycles to wait for a read response before raising err
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- if_req  input  1  fetch request; held with if_addr stable until if_gnt
- if_addr  input  ADDR_W  fetch address
- if_gnt  output  1  one-cycle pulse: fetch request accepted by memory
- if_rvalid  output  1  one-cycle pulse: if_rdata valid
- if_rdata  output  32  instruction, mem_rdata[31:0]
- ls_req  input  1  load/store request; held with all ls_* fields stable until ls_gnt
- ls_we  input  1  1 = store, 0 = load
- ls_addr  input  ADDR_W  data address
- ls_wdata  input  DATA_W  store data
- ls_len  input  4  access length in bytes: 1, 2, 4 or 8
- ls_gnt  output  1  one-cycle pulse: load/store request accepted
- ls_rvalid  output  1  one-cycle pulse: ls_rdata valid
- ls_rdata  output  DATA_W  load data, mem_rdata
- mem_req, mem_we, mem_addr, mem_wdata, mem_len  output  1/1/ADDR_W/DATA_W/4  memory command
- mem_ready  input  1  memory accepts the command in this cycle
- mem_rvalid  input  1  read data valid; never asserted in the acceptance cycle
- mem_rdata  input  DATA_W  read data
- err  output  1  sticky; cleared only by reset

## Operation
- FSM states: IDLE, WAIT_IF, WAIT_LS.
- IDLE:
  - The picker selects among the active requesters.
  - mem_req is driven combinationally from the winner, with the winner's fields muxed onto mem_*.
  - On mem_req && mem_ready:
    - the winner's gnt pulses;
    - last_owner is updated to the winner;
    - a read moves the FSM to WAIT_<owner>;
    - a write completes on acceptance and the FSM stays in IDLE.
- Round-robin: if both requesters are active, the one that is not last_owner wins. Reset value of last_owner is LS, so fetch wins the first tie.
- WAIT_x:
  - mem_req is held at 0.
  - On mem_rvalid, x_rvalid pulses with the data forwarded combinationally, and the FSM returns to IDLE.
  - A new command may be issued in the following cycle, not in the same cycle.
- Wait counter: 4 bits, cleared on entry to WAIT_x, incremented each cycle without mem_rvalid.
  - When it reaches TIMEOUT, set err, pulse x_rvalid with zero data, and return to IDLE.
  - The counter saturates and never wraps.
- Any mem_rvalid while the FSM is in IDLE sets err and is not forwarded.
- Fetch requests are always reads. if_rdata is the low 32 bits of the returned data.

## Timing
- Reset (async assert, synchronous-release usage):
  - state = IDLE, last_owner = LS, counter = 0, err = 0.
  - All gnt and rvalid outputs are 0, and mem_req is 0.
- rst asserted during WAIT: the outstanding read is abandoned and no rvalid is produced.
- Grant is combinational in the acceptance cycle, so there is zero arbitration latency when mem_ready = 1.
- mem_ready = 0: the winner keeps mem_req asserted.
  - Arbitration is not re-evaluated while that request is pending, so a newly arriving requester cannot preempt it.
  - The winner is registered in a pend_owner flop on the first unaccepted cycle.
- Read turnaround is the memory latency L ≥ 1 cycles, plus 1 idle cycle before the next issue.
- Back-to-back stores from one requester: one per cycle when mem_ready = 1.

## Structure
- mem_arb_pkg holds:
  - the state enum;
  - the owner enum IF/LS;
  - len constants LEN_B = 1, LEN_H = 2, LEN_W = 4, LEN_D = 8;
  - TIMEOUT_DEFAULT.
- Sub-module rr_pick2 is a combinational two-way round-robin picker with inputs req[1:0] and last, and output one-hot gnt.
- Flops live in mem_arbiter: state, last_owner, pend_owner, counter, err.

## Test plan
- Single fetch: if_req = 1, if_addr = 0x010, memory L = 2, data 0x00100093 → if_gnt in cycle 0, if_rvalid in cycle 2 with if_rdata = 0x00100093, ls outputs stay 0.
- Tie after reset: if_req and ls_req both asserted (ls load at 0x100) → fetch granted first, load granted one cycle after the fetch rvalid, ls_rdata returned correctly.
- Store stream: 3 stores (0x200/0x208/0x210, ls_len = 8) with mem_ready = 1 → 3 consecutive ls_gnt pulses, FSM never leaves IDLE, no rvalid.
- Backpressure: mem_ready = 0 for 3 cycles during a pending fetch, then ls_req arrives → mem_addr stays at the fetch address, no ls_gnt until the fetch completes.
- Timeout: load issued, mem_rvalid never asserted → after 15 cycles ls_rvalid = 1 with ls_rdata = 0, err = 1 and remains 1.
- Reset mid-read: rst low in WAIT_LS, later a late mem_rvalid → all outputs 0 during reset, the late rvalid sets err and produces no ls_rvalid.
